// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
// Contents: controller state encoding and default parameter values.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_STATE_RUN   = 2'd0,
    CTRL_STATE_HOLD  = 2'd1,
    CTRL_STATE_FLUSH = 2'd2
  } ctrl_state_t;

  localparam int CTRL_ADDR_WIDTH   = 32;
  localparam int CTRL_FLUSH_CYCLES = 2;
  localparam int CTRL_CNT_WIDTH    = 32;

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Enable-driven wrapping counter with synchronous reset.
// Ports:
//   clk   - clock
//   rst   - synchronous reset, active-high, clears count
//   en    - increment by one this cycle
//   count - current value, wraps modulo 2^WIDTH
module pipe_ctrl_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = CTRL_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count register: reset has priority over the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {WIDTH{1'b0}};
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the RV32I core: turns EX jump requests and
// EX/CSR/bus hold requests into PC redirect, pipeline flush and stalls.
// Jumps resolved while fetch is held are parked and replayed on release.
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   jump_enable_i, jump_addr_i   - EX-stage jump request and target
//   hold_ex_i/csr_i/bus_i        - stall requests
//   redirect_o, redirect_addr_o  - load new PC this cycle
//   flush_o                      - clear IF/ID and ID/EX
//   hold_pc_o/if_id_o/id_ex_o    - stage freezes
//   misalign_o                   - jump target not word aligned, dropped
//   jump_cnt_o, hold_cnt_o       - redirect and PC-hold cycle counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = CTRL_ADDR_WIDTH,
  parameter int FLUSH_CYCLES = CTRL_FLUSH_CYCLES,
  parameter int CNT_WIDTH    = CTRL_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  hold_ex_i,
  input  logic                  hold_csr_i,
  input  logic                  hold_bus_i,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_addr_o,
  output logic                  flush_o,
  output logic                  hold_pc_o,
  output logic                  hold_if_id_o,
  output logic                  hold_id_ex_o,
  output logic                  misalign_o,
  output logic [CNT_WIDTH-1:0]  jump_cnt_o,
  output logic [CNT_WIDTH-1:0]  hold_cnt_o
);

  // Flush counter holds the number of flush cycles still owed after the
  // redirect cycle itself.
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  ctrl_state_t           state;
  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [FCW-1:0]        flush_cnt;

  logic [ADDR_WIDTH-1:0] target;
  logic                  hold_any;
  logic                  hold_pipe;
  logic                  run_like;
  logic                  jump_ok;
  logic                  misalign;
  logic                  release_pend;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic [CNT_WIDTH-1:0]  jump_cnt;
  logic [CNT_WIDTH-1:0]  hold_cnt;

  // Request decode: a HOLD with nothing parked behaves exactly like RUN.
  always_comb begin
    target       = {jump_addr_i[ADDR_WIDTH-1:1], 1'b0};
    hold_any     = hold_ex_i | hold_csr_i | hold_bus_i;
    hold_pipe    = hold_ex_i | hold_csr_i;
    run_like     = (state == CTRL_STATE_RUN) ||
                   ((state == CTRL_STATE_HOLD) && !pend_valid);
    misalign     = run_like & jump_enable_i & target[1];
    jump_ok      = run_like & jump_enable_i & ~target[1];
    release_pend = (state == CTRL_STATE_HOLD) & pend_valid & ~hold_any;
    redirect     = release_pend | (jump_ok & ~hold_any);
    if (release_pend) begin
      redirect_addr = pend_addr;
    end else if (redirect) begin
      redirect_addr = target;
    end else begin
      redirect_addr = {ADDR_WIDTH{1'b0}};
    end
  end

  // Controller FSM with the parked-jump register and flush counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= CTRL_STATE_RUN;
      pend_valid <= 1'b0;
      pend_addr  <= {ADDR_WIDTH{1'b0}};
      flush_cnt  <= {FCW{1'b0}};
    end else begin
      case (state)
        CTRL_STATE_RUN, CTRL_STATE_HOLD: begin
          if (redirect) begin
            pend_valid <= 1'b0;
            if (FLUSH_CYCLES > 1) begin
              state     <= CTRL_STATE_FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end else begin
              state <= CTRL_STATE_RUN;
            end
          end else if (hold_any) begin
            state <= CTRL_STATE_HOLD;
            // jump_ok is already false once a target is parked.
            if (jump_ok) begin
              pend_valid <= 1'b1;
              pend_addr  <= target;
            end
          end else begin
            state <= CTRL_STATE_RUN;
          end
        end
        CTRL_STATE_FLUSH: begin
          // The flush freezes along with the PC while any hold is active.
          if (!hold_any) begin
            if (flush_cnt <= FCW'(1)) begin
              state     <= CTRL_STATE_RUN;
              flush_cnt <= {FCW{1'b0}};
            end else begin
              flush_cnt <= flush_cnt - FCW'(1);
            end
          end
        end
        default: begin
          state      <= CTRL_STATE_RUN;
          pend_valid <= 1'b0;
          flush_cnt  <= {FCW{1'b0}};
        end
      endcase
    end
  end

  pipe_ctrl_cnt #(.WIDTH(CNT_WIDTH)) u_jump_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (redirect),
    .count (jump_cnt)
  );

  pipe_ctrl_cnt #(.WIDTH(CNT_WIDTH)) u_hold_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (hold_any),
    .count (hold_cnt)
  );

  // Every output is forced low while reset is asserted.
  always_comb begin
    if (rst_i) begin
      redirect_o      = 1'b0;
      redirect_addr_o = {ADDR_WIDTH{1'b0}};
      flush_o         = 1'b0;
      hold_pc_o       = 1'b0;
      hold_if_id_o    = 1'b0;
      hold_id_ex_o    = 1'b0;
      misalign_o      = 1'b0;
      jump_cnt_o      = {CNT_WIDTH{1'b0}};
      hold_cnt_o      = {CNT_WIDTH{1'b0}};
    end else begin
      redirect_o      = redirect;
      redirect_addr_o = redirect_addr;
      flush_o         = redirect | (state == CTRL_STATE_FLUSH);
      hold_pc_o       = hold_any;
      hold_if_id_o    = hold_pipe;
      hold_id_ex_o    = hold_pipe;
      misalign_o      = misalign;
      jump_cnt_o      = jump_cnt;
      hold_cnt_o      = hold_cnt;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the RV32I core.
- Consumes the jump request (enable + target) produced by the EX-stage branch/jump unit and the multi-cycle hold requests from EX, CSR and the bus.
- Sequences PC redirect, multi-cycle pipeline flush and stage stalls, including jumps that resolve while fetch is stalled.
- Sits between the exe stage and the pc_reg / if_id / id_ex pipeline registers.

Parameters:
- ADDR_WIDTH, 32, width of PC and jump target (from defines.v `ADDR_WIDTH)
- FLUSH_CYCLES, 2, cycles flush_o stays high per redirect (>=1; 2 = bubble IF/ID and ID/EX)
- CNT_WIDTH, 32, width of the performance counters

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- jump_enable_i  in  1  EX-stage branch taken / JAL / JALR
- jump_addr_i  in  ADDR_WIDTH  EX-stage jump target
- hold_ex_i  in  1  multi-cycle EX op in progress
- hold_csr_i  in  1  CSR access stall
- hold_bus_i  in  1  instruction-fetch bus not ready
- redirect_o  out  1  load redirect_addr_o into PC this cycle
- redirect_addr_o  out  ADDR_WIDTH  new PC
- flush_o  out  1  clear IF/ID and ID/EX to NOP
- hold_pc_o  out  1  freeze PC
- hold_if_id_o  out  1  freeze IF/ID register
- hold_id_ex_o  out  1  freeze ID/EX register
- misalign_o  out  1  one-cycle pulse: jump target not 4-byte aligned, jump dropped
- jump_cnt_o  out  CNT_WIDTH  count of redirects issued
- hold_cnt_o  out  CNT_WIDTH  count of cycles with hold_pc_o=1

Behaviour:
- Reset (rst_i=1 at posedge): state=RUN, flush counter=0, pend_valid=0, pend_addr=0, counters=0.
  - All outputs are 0 while rst_i=1 (combinational outputs gated by rst_i).
- States:
  - RUN: normal operation.
  - HOLD: at least one hold request active.
  - FLUSH: flush counter running.
- Stall mapping (all combinational, any state):
  - hold_pc_o = hold_ex_i | hold_csr_i | hold_bus_i.
  - hold_if_id_o = hold_id_ex_o = hold_ex_i | hold_csr_i.
  - Bus hold freezes only the PC.
- Target check: effective target = jump_addr_i with bit0 forced to 0.
  - If bit1 = 1: misalign_o = 1 that cycle, no redirect, no flush, no capture, jump_cnt_o unchanged.
- RUN, jump_enable_i=1, hold_pc_o=0, target aligned (zero latency):
  - Same cycle: redirect_o=1, redirect_addr_o=target, flush_o=1.
  - jump_cnt_o increments.
  - Next state FLUSH with counter = FLUSH_CYCLES-1; if FLUSH_CYCLES=1, stay in RUN.
- RUN, any hold active:
  - No redirect.
  - If jump_enable_i=1 and target aligned: capture pend_addr=target, pend_valid=1.
  - Next state HOLD.
- HOLD:
  - jump_enable_i captured only while pend_valid=0; later assertions (same instruction held in EX) are ignored.
  - First cycle with all holds low (release cycle):
    - If pend_valid=1: redirect_o=1, redirect_addr_o=pend_addr, flush_o=1, clear pend_valid, increment jump_cnt_o, go to FLUSH (or RUN if FLUSH_CYCLES=1). jump_enable_i is ignored in this cycle.
    - Else: behave exactly as RUN in this same cycle.
- FLUSH:
  - flush_o=1; jump_enable_i ignored (the instruction has been flushed).
  - Counter decrements only on cycles with hold_pc_o=0; it freezes while a hold is active, with flush_o kept high.
  - When counter reaches 0, return to RUN on the next edge.
- Priority within one cycle: reset > misalign check > hold > redirect.
  - redirect_o and hold_pc_o are never both 1.
- Counters:
  - Wrap modulo 2^CNT_WIDTH.
  - hold_cnt_o increments on every cycle with hold_pc_o=1, in any state.
- Reset mid-operation (in HOLD with pend_valid, or mid-FLUSH) discards the pending jump and the flush. RUN starts next cycle.

Decomposition:
- defines.v gains:
  - CTRL_STATE_RUN=2'd0, CTRL_STATE_HOLD=2'd1, CTRL_STATE_FLUSH=2'd2
  - `CTRL_FLUSH_CYCLES default
  - reuse of `ZERO / `ADDR_WIDTH
- One sub-module: pipe_ctrl_cnt, a CNT_WIDTH enable-driven wrapping counter with synchronous reset, instantiated twice (jump_cnt, hold_cnt).
- FSM, pending register and flush counter stay in pipe_ctrl.

Test Plan:
- Taken jump in RUN: jump_enable_i=1, jump_addr_i=0x100, no holds → same cycle redirect_o=1, redirect_addr_o=0x100, flush_o=1. flush_o stays 1 one more cycle then 0. jump_cnt_o=1.
- Jump during bus hold: hold_bus_i=1 for 3 cycles, jump to 0x2C0 in hold cycle 1 → hold_pc_o=1, hold_if_id_o=0, no redirect for 3 cycles. Release cycle gives redirect_addr_o=0x2C0, flush_o=1. hold_cnt_o=3.
- EX hold with jump held 4 cycles: hold_ex_i=1 and jump_enable_i=1 (0x80) for 4 cycles, then hold drops → exactly one redirect to 0x80. jump_cnt_o=1. jump_enable_i in the release cycle is ignored.
- Misaligned target: jump to 0x102 → misalign_o=1 for 1 cycle, redirect_o=0, flush_o=0, jump_cnt_o unchanged. Target 0x101 → redirect to 0x100.
- Hold during FLUSH: redirect, then hold_csr_i=1 for 2 cycles in the first flush cycle → flush_o stays 1 for 1+2+1 cycles. No redirect in that window.
- Reset mid-HOLD with pend_valid=1 → next cycle all outputs 0, no redirect after release. Counters=0.
